// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires the ROB head, drives the single register-file
// commit port, hands stores to the LSB, raises the mispredict flush and latches halt.
module commit_ctrl #(
    parameter int ROB_SIZE_WIDTH = 4,
    parameter int REG_NUM_WIDTH  = 5,
    parameter int FLUSH_CYCLES   = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      head_valid,
    input  logic                      head_ready,
    input  logic [1:0]                head_type,
    input  logic [REG_NUM_WIDTH-1:0]  head_rd,
    input  logic [31:0]               head_value,
    input  logic [ROB_SIZE_WIDTH-1:0] head_tag,
    input  logic                      head_mispredict,
    input  logic [31:0]               head_target,
    input  logic                      store_done,
    output logic                      head_pop,
    output logic                      rf_valid,
    output logic [REG_NUM_WIDTH-1:0]  rf_rd,
    output logic [31:0]               rf_value,
    output logic [ROB_SIZE_WIDTH-1:0] rf_tag,
    output logic                      store_req,
    output logic [ROB_SIZE_WIDTH-1:0] store_tag,
    output logic                      flush_out,
    output logic [31:0]               flush_pc,
    output logic                      halt_out,
    output logic [31:0]               commit_count
);

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;
    localparam logic [1:0] TYPE_HALT   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_STORE = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
    logic                      rf_valid_q, rf_valid_d;
    logic [REG_NUM_WIDTH-1:0]  rf_rd_q, rf_rd_d;
    logic [31:0]               rf_value_q, rf_value_d;
    logic [ROB_SIZE_WIDTH-1:0] rf_tag_q, rf_tag_d;
    logic                      store_req_q, store_req_d;
    logic [ROB_SIZE_WIDTH-1:0] store_tag_q, store_tag_d;
    logic                      flush_out_q, flush_out_d;
    logic [31:0]               flush_pc_q, flush_pc_d;
    logic                      halt_q, halt_d;
    logic [31:0]               commit_count_q, commit_count_d;
    logic                      pop_s;
    logic                      rf_write_s;

    // Next-state, pop decision and commit-port/flush/store/halt register updates.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        rf_valid_d     = rf_valid_q;
        rf_rd_d        = rf_rd_q;
        rf_value_d     = rf_value_q;
        rf_tag_d       = rf_tag_q;
        store_req_d    = store_req_q;
        store_tag_d    = store_tag_q;
        flush_out_d    = flush_out_q;
        flush_pc_d     = flush_pc_q;
        halt_d         = halt_q;
        commit_count_d = commit_count_q;
        pop_s          = 1'b0;
        rf_write_s     = 1'b0;

        if (rdy_in && !rst_in) begin
            rf_valid_d  = 1'b0;
            flush_out_d = 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (head_valid && head_ready) begin
                        case (head_type)
                            TYPE_REG: begin
                                pop_s      = 1'b1;
                                rf_write_s = (head_rd != {REG_NUM_WIDTH{1'b0}});
                            end
                            TYPE_STORE: begin
                                store_req_d = 1'b1;
                                store_tag_d = head_tag;
                                state_d     = ST_WAIT_STORE;
                            end
                            TYPE_BRANCH: begin
                                pop_s      = 1'b1;
                                rf_write_s = (head_rd != {REG_NUM_WIDTH{1'b0}});
                                if (head_mispredict) begin
                                    flush_out_d = 1'b1;
                                    flush_pc_d  = head_target;
                                    flush_cnt_d = FLUSH_LOAD;
                                    state_d     = ST_FLUSH;
                                end else begin
                                    state_d = ST_RUN;
                                end
                            end
                            TYPE_HALT: begin
                                pop_s   = 1'b1;
                                halt_d  = 1'b1;
                                state_d = ST_HALTED;
                            end
                            default: begin
                                state_d = state_q;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT_STORE: begin
                    // The head type is not re-examined: the LSB completion alone retires the store.
                    if (store_done) begin
                        pop_s       = 1'b1;
                        store_req_d = 1'b0;
                        state_d     = ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_d = flush_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (flush_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            if (rf_write_s) begin
                rf_valid_d = 1'b1;
                rf_rd_d    = head_rd;
                rf_value_d = head_value;
                rf_tag_d   = head_tag;
            end else begin
                rf_valid_d = 1'b0;
            end

            if (pop_s) begin
                commit_count_d = commit_count_q + 32'd1;
            end else begin
                commit_count_d = commit_count_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= ST_RUN;
            flush_cnt_q    <= {CNT_W{1'b0}};
            rf_valid_q     <= 1'b0;
            rf_rd_q        <= {REG_NUM_WIDTH{1'b0}};
            rf_value_q     <= 32'd0;
            rf_tag_q       <= {ROB_SIZE_WIDTH{1'b0}};
            store_req_q    <= 1'b0;
            store_tag_q    <= {ROB_SIZE_WIDTH{1'b0}};
            flush_out_q    <= 1'b0;
            flush_pc_q     <= 32'd0;
            halt_q         <= 1'b0;
            commit_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            rf_valid_q     <= rf_valid_d;
            rf_rd_q        <= rf_rd_d;
            rf_value_q     <= rf_value_d;
            rf_tag_q       <= rf_tag_d;
            store_req_q    <= store_req_d;
            store_tag_q    <= store_tag_d;
            flush_out_q    <= flush_out_d;
            flush_pc_q     <= flush_pc_d;
            halt_q         <= halt_d;
            commit_count_q <= commit_count_d;
        end
    end

    assign head_pop     = pop_s;
    assign rf_valid     = rf_valid_q;
    assign rf_rd        = rf_rd_q;
    assign rf_value     = rf_value_q;
    assign rf_tag       = rf_tag_q;
    assign store_req    = store_req_q;
    assign store_tag    = store_tag_q;
    assign flush_out    = flush_out_q;
    assign flush_pc     = flush_pc_q;
    assign halt_out     = halt_q;
    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed self-checking bench for commit_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_commit_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        head_valid;
    logic        head_ready;
    logic [1:0]  head_type;
    logic [4:0]  head_rd;
    logic [31:0] head_value;
    logic [3:0]  head_tag;
    logic        head_mispredict;
    logic [31:0] head_target;
    logic        store_done;
    logic        head_pop;
    logic        rf_valid;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value;
    logic [3:0]  rf_tag;
    logic        store_req;
    logic [3:0]  store_tag;
    logic        flush_out;
    logic [31:0] flush_pc;
    logic        halt_out;
    logic [31:0] commit_count;

    int tests = 0;
    int fails = 0;

    commit_ctrl #(.ROB_SIZE_WIDTH(4), .REG_NUM_WIDTH(5), .FLUSH_CYCLES(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
        .head_rd(head_rd), .head_value(head_value), .head_tag(head_tag),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .store_done(store_done), .head_pop(head_pop),
        .rf_valid(rf_valid), .rf_rd(rf_rd), .rf_value(rf_value), .rf_tag(rf_tag),
        .store_req(store_req), .store_tag(store_tag),
        .flush_out(flush_out), .flush_pc(flush_pc),
        .halt_out(halt_out), .commit_count(commit_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic set_head(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] v, input logic [3:0] tag);
        head_valid = 1'b1; head_ready = 1'b1; head_type = t;
        head_rd = rd; head_value = v; head_tag = tag;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; head_valid = 1'b0; head_ready = 1'b0;
        head_type = 2'd0; head_rd = 5'd0; head_value = 32'd0; head_tag = 4'd0;
        head_mispredict = 1'b0; head_target = 32'd0; store_done = 1'b0;
        #12;
        tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL rst_pop: got %b exp 0", head_pop); end
        tests++; if (rf_valid !== 1'b0 || rf_rd !== 5'd0 || rf_value !== 32'd0 || rf_tag !== 4'd0) begin fails++; $display("FAIL rst_rf: got %b %h %h %h exp zeros", rf_valid, rf_rd, rf_value, rf_tag); end
        tests++; if (store_req !== 1'b0 || store_tag !== 4'd0 || flush_out !== 1'b0 || flush_pc !== 32'd0) begin fails++; $display("FAIL rst_misc: got %b %h %b %h exp zeros", store_req, store_tag, flush_out, flush_pc); end
        tests++; if (halt_out !== 1'b0 || commit_count !== 32'd0) begin fails++; $display("FAIL rst_halt_cnt: got %b %0d exp 0 0", halt_out, commit_count); end
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (head_pop !== 1'b0 || rf_valid !== 1'b0 || store_req !== 1'b0 || commit_count !== 32'd0) begin fails++; $display("FAIL idle_%0d: got pop=%b rfv=%b sreq=%b cnt=%0d exp 0 0 0 0", i, head_pop, rf_valid, store_req, commit_count); end
        end
    endtask

    task automatic test_reg();
        set_head(2'd0, 5'd5, 32'h1234, 4'd3);
        #1;
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL reg_pop: got %b exp 1", head_pop); end
        step();
        tests++; if (rf_valid !== 1'b1 || rf_rd !== 5'd5 || rf_value !== 32'h1234 || rf_tag !== 4'd3) begin fails++; $display("FAIL reg_write: got %b %0d %h %0d exp 1 5 1234 3", rf_valid, rf_rd, rf_value, rf_tag); end
        tests++; if (commit_count !== 32'd1) begin fails++; $display("FAIL reg_cnt1: got %0d exp 1", commit_count); end
        set_head(2'd0, 5'd0, 32'h5555, 4'd4);
        #1;
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL reg0_pop: got %b exp 1", head_pop); end
        step();
        tests++; if (rf_valid !== 1'b0 || commit_count !== 32'd2) begin fails++; $display("FAIL reg0_nowrite: got rfv=%b cnt=%0d exp 0 2", rf_valid, commit_count); end
        head_valid = 1'b0;
    endtask

    task automatic test_stall();
        set_head(2'd0, 5'd7, 32'h77, 4'd1);
        head_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL notready_pop_%0d: got %b exp 0", i, head_pop); end
            step();
            tests++; if (rf_valid !== 1'b0 || commit_count !== 32'd2) begin fails++; $display("FAIL notready_state_%0d: got rfv=%b cnt=%0d exp 0 2", i, rf_valid, commit_count); end
        end
        head_ready = 1'b1;
        step();
        tests++; if (rf_valid !== 1'b1 || rf_rd !== 5'd7 || commit_count !== 32'd3) begin fails++; $display("FAIL ready_commit: got rfv=%b rd=%0d cnt=%0d exp 1 7 3", rf_valid, rf_rd, commit_count); end
        rdy_in = 1'b0;
        set_head(2'd0, 5'd8, 32'h88, 4'd2);
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL rdylow_pop_%0d: got %b exp 0", i, head_pop); end
            step();
            tests++; if (rf_valid !== 1'b1 || rf_rd !== 5'd7 || commit_count !== 32'd3) begin fails++; $display("FAIL rdylow_hold_%0d: got rfv=%b rd=%0d cnt=%0d exp 1 7 3", i, rf_valid, rf_rd, commit_count); end
        end
        rdy_in = 1'b1;
        #1;
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL rdyhigh_pop: got %b exp 1", head_pop); end
        step();
        tests++; if (rf_valid !== 1'b1 || rf_rd !== 5'd8 || rf_value !== 32'h88 || commit_count !== 32'd4) begin fails++; $display("FAIL rdyhigh_commit: got %b %0d %h %0d exp 1 8 88 4", rf_valid, rf_rd, rf_value, commit_count); end
        head_valid = 1'b0;
    endtask

    task automatic test_store();
        set_head(2'd1, 5'd9, 32'h99, 4'd6);
        #1;
        tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL store_nopop: got %b exp 0", head_pop); end
        step();
        tests++; if (store_req !== 1'b1 || store_tag !== 4'd6 || head_pop !== 1'b0) begin fails++; $display("FAIL store_req: got req=%b tag=%0d pop=%b exp 1 6 0", store_req, store_tag, head_pop); end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (head_pop !== 1'b0 || store_req !== 1'b1 || commit_count !== 32'd4) begin fails++; $display("FAIL store_wait_%0d: got pop=%b req=%b cnt=%0d exp 0 1 4", i, head_pop, store_req, commit_count); end
        end
        store_done = 1'b1;
        #1;
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL store_done_pop: got %b exp 1", head_pop); end
        step();
        head_valid = 1'b0;
        tests++; if (store_req !== 1'b0 || commit_count !== 32'd5) begin fails++; $display("FAIL store_retire: got req=%b cnt=%0d exp 0 5", store_req, commit_count); end
        #1;
        tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL run_storedone_pop: got %b exp 0", head_pop); end
        step();
        store_done = 1'b0;
        tests++; if (commit_count !== 32'd5 || store_req !== 1'b0) begin fails++; $display("FAIL run_storedone_cnt: got cnt=%0d req=%b exp 5 0", commit_count, store_req); end
    endtask

    task automatic test_branch_flush();
        set_head(2'd2, 5'd1, 32'h2008, 4'd2);
        head_mispredict = 1'b1; head_target = 32'h100;
        #1;
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL br_pop: got %b exp 1", head_pop); end
        step();
        head_mispredict = 1'b0;
        tests++; if (rf_valid !== 1'b1 || rf_rd !== 5'd1 || rf_value !== 32'h2008 || commit_count !== 32'd6) begin fails++; $display("FAIL br_write: got %b %0d %h %0d exp 1 1 2008 6", rf_valid, rf_rd, rf_value, commit_count); end
        tests++; if (flush_out !== 1'b1 || flush_pc !== 32'h100) begin fails++; $display("FAIL br_flush: got %b %h exp 1 100", flush_out, flush_pc); end
        set_head(2'd0, 5'd3, 32'h33, 4'd4);
        #1;
        tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL flush_nopop1: got %b exp 0", head_pop); end
        step();
        tests++; if (flush_out !== 1'b0 || rf_valid !== 1'b0 || head_pop !== 1'b0) begin fails++; $display("FAIL flush_cycle2: got flush=%b rfv=%b pop=%b exp 0 0 0", flush_out, rf_valid, head_pop); end
        step();
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL flush_resume_pop: got %b exp 1", head_pop); end
        step();
        head_valid = 1'b0;
        tests++; if (rf_valid !== 1'b1 || rf_rd !== 5'd3 || rf_value !== 32'h33 || commit_count !== 32'd7) begin fails++; $display("FAIL flush_resume_commit: got %b %0d %h %0d exp 1 3 33 7", rf_valid, rf_rd, rf_value, commit_count); end
    endtask

    task automatic test_halt();
        set_head(2'd3, 5'd0, 32'd0, 4'd5);
        #1;
        tests++; if (head_pop !== 1'b1) begin fails++; $display("FAIL halt_pop: got %b exp 1", head_pop); end
        step();
        set_head(2'd0, 5'd2, 32'h22, 4'd6);
        tests++; if (halt_out !== 1'b1 || commit_count !== 32'd8) begin fails++; $display("FAIL halt_set: got %b %0d exp 1 8", halt_out, commit_count); end
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL halted_pop_%0d: got %b exp 0", i, head_pop); end
            step();
            tests++; if (halt_out !== 1'b1 || rf_valid !== 1'b0 || commit_count !== 32'd8) begin fails++; $display("FAIL halted_hold_%0d: got halt=%b rfv=%b cnt=%0d exp 1 0 8", i, halt_out, rf_valid, commit_count); end
        end
        head_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        #2 rst_in = 1'b1;
        #1;
        tests++; if (halt_out !== 1'b0 || commit_count !== 32'd0) begin fails++; $display("FAIL async_halt: got halt=%b cnt=%0d exp 0 0", halt_out, commit_count); end
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        set_head(2'd1, 5'd0, 32'd0, 4'd9);
        step();
        head_valid = 1'b0;
        tests++; if (store_req !== 1'b1 || store_tag !== 4'd9) begin fails++; $display("FAIL async_pre_store: got %b %0d exp 1 9", store_req, store_tag); end
        #2 rst_in = 1'b1;
        #1;
        tests++; if (store_req !== 1'b0 || store_tag !== 4'd0) begin fails++; $display("FAIL async_store: got %b %0d exp 0 0", store_req, store_tag); end
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        store_done = 1'b1;
        #1;
        tests++; if (head_pop !== 1'b0) begin fails++; $display("FAIL post_rst_run: got pop=%b exp 0", head_pop); end
        store_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reg();
        test_stall();
        test_store();
        test_branch_flush();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- In-order commit sequencer between the reorder buffer head and the register file.
- Decides when the ROB head retires and owns the register file's single commit write port (rob_valid/rob_rd/rob_value/rob_dependency).
- Sequences store commits with the load/store buffer, raises the pipeline flush on a branch mispredict, and latches halt.

Parameters:
- ROB_SIZE_WIDTH, `ROB_SIZE_WIDTH: ROB tag width.
- REG_NUM_WIDTH, `REG_NUM_WIDTH: architectural register index width.
- FLUSH_CYCLES, 1: cycles the block stays in FLUSH after raising flush_out (>=1).

Ports:
- clk_in  in  1  clock; all state on rising edge.
- rst_in  in  1  reset; asynchronous, active-high.
- rdy_in  in  1  global ready; low freezes the block.
- head_valid  in  1  ROB head entry exists.
- head_ready  in  1  head result available.
- head_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 HALT.
- head_rd  in  REG_NUM_WIDTH  destination register.
- head_value  in  32  result value (link value for BRANCH).
- head_tag  in  ROB_SIZE_WIDTH  ROB index of head.
- head_mispredict  in  1  BRANCH head was mispredicted.
- head_target  in  32  correct PC for mispredicted BRANCH.
- store_done  in  1  LSB finished memory write of committed store.
- head_pop  out  1  combinational; ROB dequeues head on this edge.
- rf_valid  out  1  registered RF commit write strobe.
- rf_rd  out  REG_NUM_WIDTH  registered RF write index.
- rf_value  out  32  registered RF write data.
- rf_tag  out  ROB_SIZE_WIDTH  registered ROB tag, for dependency clear.
- store_req  out  1  registered; store at head may write memory.
- store_tag  out  ROB_SIZE_WIDTH  registered tag of that store.
- flush_out  out  1  registered one-cycle flush pulse.
- flush_pc  out  32  registered redirect PC.
- halt_out  out  1  sticky halt.
- commit_count  out  32  retired-instruction counter.

Behaviour:
- Reset (async, any state): state=RUN. All registered outputs 0, including commit_count, halt_out and FLUSH counter.
- rdy_in low: no state or register change; head_pop=0. Registered outputs hold; all consumers are rdy-gated.
- head_pop is combinational from current state and head inputs. Every other output is registered and asserts on the edge that pops, i.e. visible the cycle after head_pop.
- Pulsed registers (rf_valid, flush_out) default to 0 every active cycle unless set by a commit.
- At most one commit per cycle.
- Every pop increments commit_count by 1; the counter wraps at 2^32.
- State RUN, head_valid && head_ready required; otherwise no action.
  - REG: pop. rf_valid=1 with rd/value/tag if head_rd!=0; no write if head_rd==0.
  - STORE: no pop. store_req<=1, store_tag<=head_tag, go WAIT_STORE.
  - BRANCH, not mispredicted: pop; RF write as REG (rd!=0 only).
  - BRANCH, mispredicted: pop; RF write as REG; flush_out<=1, flush_pc<=head_target; load FLUSH counter with FLUSH_CYCLES; go FLUSH.
  - HALT: pop; halt_out<=1; go HALTED.
- State WAIT_STORE:
  - Ignore head_type. When store_done: pop, store_req<=0, go RUN.
  - store_done in the same cycle store_req is first set is ignored; store_done in RUN is ignored.
- State FLUSH:
  - No pop, no RF write; counter decrements each active cycle.
  - When counter reaches 0 (after FLUSH_CYCLES cycles), go RUN.
  - Head inputs are don't-care in FLUSH; the ROB is being cleared.
- State HALTED: no pop, no outputs change except holds; exit only by reset.
- Reset mid WAIT_STORE or FLUSH: returns to RUN immediately; store_req and flush_out drop asynchronously.

Test Plan:
- Reset -> all outputs 0, head_pop=0. Release reset with head_valid=0 -> nothing changes for 5 cycles.
- REG commit: head_ready=1, rd=5, value=0x1234, tag=3 -> head_pop=1 that cycle. Next cycle rf_valid=1, rf_rd=5, rf_value=0x1234, rf_tag=3, commit_count=1. Repeat with rd=0 -> pop, rf_valid stays 0, count=2.
- head_valid=1, head_ready=0 for 4 cycles -> no pop, no RF write. Toggle rdy_in low with ready head -> no pop while low.
- STORE: tag=6 -> next cycle store_req=1, store_tag=6, no pop. store_done after 3 cycles -> head_pop=1 that cycle; store_req=0 next cycle; count+1.
- Mispredicted BRANCH: rd=1, value=0x2008, target=0x100, FLUSH_CYCLES=2 -> pop. Next cycle rf_valid=1 (x1=0x2008), flush_out=1 for exactly one cycle, flush_pc=0x100. No pop for 2 cycles even with a ready head, then REG commits resume.
- HALT -> halt_out=1 sticky, no further pops. Assert rst_in asynchronously mid WAIT_STORE -> store_req and halt_out fall without a clock edge.
